// File: rtl/shift_issue_pipe_if.sv
// Issue/writeback handshake bundle for the pipelined shift unit.
// The issuer drives requests and consumes results; the unit is the slave.
interface shift_issue_pipe_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [4:0]       in_shamt;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/shift_issue_pipe.sv
// Two-stage valid/ready shift unit: stage 1 conditions operands, stage 2 runs
// the logical-right core and post-processes into SLL/SRL/SRA/ROR results.
module shift_core (
   input  logic [31:0] x,
   input  logic [4:0]  shamt,
   output logic [31:0] r
);
   always_comb begin
      r = x;
      for (int i = 0; i < 5; i++) begin
         if (shamt[i]) r = r >> (1 << i);
      end
   end
endmodule

module shift_issue_pipe #(
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   shift_issue_pipe_if.slave   bus,
   output logic [1:0]          occupancy
);
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   function automatic logic [31:0] bitrev(input logic [31:0] v);
      logic [31:0] o;
      for (int i = 0; i < 32; i++) o[i] = v[31-i];
      return o;
   endfunction

   logic             s1_valid, s2_valid;
   logic [31:0]      s1_a, s1_x;
   logic [4:0]       s1_shamt;
   logic [1:0]       s1_op;
   logic [TAG_W-1:0] s1_tag;
   logic [31:0]      s2_result;
   logic [TAG_W-1:0] s2_tag;

   logic        s2_adv, s1_adv, accept;
   logic [31:0] core_r, fill, wrap, s2_next;
   logic [5:0]  wrap_sh;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = s1_valid && s2_adv;
   assign bus.in_ready = !flush && (!s1_valid || s2_adv);
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.out_valid  = s2_valid && !flush;
   assign bus.out_result = s2_result;
   assign bus.out_tag    = s2_tag;
   assign occupancy      = {1'b0, s1_valid} + {1'b0, s2_valid};

   shift_core u_core (
      .x     (s1_x),
      .shamt (s1_shamt),
      .r     (core_r)
   );

   // Rotate wrap term is gated at shamt=0 so the 32-bit left shift never aliases.
   assign wrap_sh = 6'd32 - {1'b0, s1_shamt};
   assign wrap    = (s1_shamt == 5'd0) ? 32'h0 : (s1_a << wrap_sh);
   assign fill    = s1_a[31] ? ~(32'hFFFF_FFFF >> s1_shamt) : 32'h0;

   always_comb begin
      s2_next = core_r;
      case (s1_op)
         OP_SLL:  s2_next = bitrev(core_r);
         OP_SRL:  s2_next = core_r;
         OP_SRA:  s2_next = core_r | fill;
         default: s2_next = core_r | wrap;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s1_a      <= '0;
         s1_x      <= '0;
         s1_shamt  <= '0;
         s1_op     <= '0;
         s1_tag    <= '0;
         s2_result <= '0;
         s2_tag    <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_adv) s2_valid <= s1_valid;
         if (s1_adv) begin
            s2_result <= s2_next;
            s2_tag    <= s1_tag;
         end
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (accept) begin
            s1_a     <= bus.in_a;
            s1_x     <= (bus.in_op == OP_SLL) ? bitrev(bus.in_a) : bus.in_a;
            s1_shamt <= bus.in_shamt;
            s1_op    <= bus.in_op;
            s1_tag   <= bus.in_tag;
         end
      end
   end
endmodule

// File: tb/tb_shift_issue_pipe.sv
// Randomized and directed bench for shift_issue_pipe against an in-order
// queue model of the shift semantics.
module tb_shift_issue_pipe;
   localparam int TAG_W = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] occupancy;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;

   shift_issue_pipe_if #(.TAG_W(TAG_W)) ifc ();

   shift_issue_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .bus       (ifc.slave),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      int               k;
   } item_t;

   item_t q[$];
   item_t dlog[$];

   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                             input logic [4:0] sh);
      logic [63:0] d;
      logic signed [31:0] sa;
      case (op)
         2'd0: return a << sh;
         2'd1: return a >> sh;
         2'd2: begin sa = a; return 32'(sa >>> sh); end
         default: begin d = {a, a} >> sh; return d[31:0]; end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the queue model, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         int sz;
         logic exp_rdy, exp_vld;
         item_t it;
         sz = q.size();
         exp_rdy = !flush && (sz < 2 || ifc.out_ready);
         exp_vld = !flush && sz > 0 && (cyc >= q[0].k + 2);
         chk("occupancy", 32'(occupancy), 32'(sz));
         chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
         chk("out_valid", 32'(ifc.out_valid), 32'(exp_vld));
         if (exp_vld && ifc.out_valid) begin
            chk("out_result", ifc.out_result, q[0].res);
            chk("out_tag", 32'(ifc.out_tag), 32'(q[0].tag));
         end
         if (flush) begin
            q.delete();
         end else begin
            if (ifc.out_valid && ifc.out_ready && sz > 0) begin
               it = q.pop_front();
               it.k = cyc;
               dlog.push_back(it);
            end
            if (ifc.in_valid && ifc.in_ready) begin
               it.res = ref_shift(ifc.in_op, ifc.in_a, ifc.in_shamt);
               it.tag = ifc.in_tag;
               it.k   = cyc;
               q.push_back(it);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifc.in_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                       input logic [TAG_W-1:0] tag);
      bit done = 0;
      ifc.in_valid = 1'b1;
      ifc.in_op    = op;
      ifc.in_a     = a;
      ifc.in_shamt = sh;
      ifc.in_tag   = tag;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = ifc.in_ready;
         tick();
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      idle();
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 30 && q.size() != 0; i++) tick();
      tick();
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int base;
      logic [31:0] held;
      ifc.in_valid  = 1'b0;
      ifc.in_a      = '0;
      ifc.in_shamt  = '0;
      ifc.in_op     = '0;
      ifc.in_tag    = '0;
      ifc.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_result", ifc.out_result, 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // SLL 1 by 31, result visible exactly two cycles after acceptance
      send(2'd0, 32'h0000_0001, 5'd31, 4'd1);
      idle();
      tick();
      chk("sll_valid", 32'(ifc.out_valid), 32'd1);
      chk("sll_result", ifc.out_result, 32'h8000_0000);
      chk("sll_tag", 32'(ifc.out_tag), 32'd1);
      drain();

      base = dlog.size();
      send(2'd2, 32'h8000_0000, 5'd4, 4'd2);
      send(2'd1, 32'h8000_0000, 5'd4, 4'd3);
      drain();
      chk("sra_result", dlog[base].res, 32'hF800_0000);
      chk("srl_result", dlog[base+1].res, 32'h0800_0000);
      chk("b2b_consecutive", 32'(dlog[base+1].k - dlog[base].k), 32'd1);

      base = dlog.size();
      send(2'd3, 32'h1234_5678, 5'd8, 4'd4);
      send(2'd3, 32'h1234_5678, 5'd0, 4'd5);
      send(2'd3, 32'h1234_5678, 5'd31, 4'd6);
      drain();
      chk("ror8", dlog[base].res, 32'h7812_3456);
      chk("ror0", dlog[base+1].res, 32'h1234_5678);
      chk("ror31", dlog[base+2].res, 32'h2468_ACF0);

      // backpressure
      base = dlog.size();
      ifc.out_ready = 1'b0;
      send(2'd1, 32'hA5A5_0000, 5'd3, 4'd1);
      send(2'd0, 32'h0000_00F0, 5'd2, 4'd2);
      ifc.in_valid = 1'b1;
      ifc.in_op    = 2'd2;
      ifc.in_a     = 32'h8000_1234;
      ifc.in_shamt = 5'd1;
      ifc.in_tag   = 4'd3;
      @(negedge clk);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("bp_occupancy", 32'(occupancy), 32'd2);
      held = ifc.out_result;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_stable", ifc.out_result, held);
      end
      ifc.out_ready = 1'b1;
      send(2'd2, 32'h8000_1234, 5'd1, 4'd3);
      drain();
      chk("bp_count", 32'(dlog.size() - base), 32'd3);
      chk("bp_tag1", 32'(dlog[base].tag), 32'd1);
      chk("bp_tag2", 32'(dlog[base+1].tag), 32'd2);
      chk("bp_tag3", 32'(dlog[base+2].tag), 32'd3);
      chk("bp_res3", dlog[base+2].res, 32'hC000_091A);

      // flush with both stages full and a request offered
      ifc.out_ready = 1'b0;
      send(2'd1, 32'hFFFF_0000, 5'd4, 4'd7);
      send(2'd1, 32'h0F0F_0F0F, 5'd4, 4'd8);
      flush = 1'b1;
      ifc.in_valid = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("flush_in_ready", 32'(ifc.in_ready), 32'd0);
      tick();
      flush = 1'b0;
      idle();
      chk("flush_occupancy", 32'(occupancy), 32'd0);
      base = dlog.size();
      ifc.out_ready = 1'b1;
      repeat (5) tick();
      chk("flush_no_result", 32'(dlog.size() - base), 32'd0);

      // asynchronous reset mid-operation
      ifc.out_ready = 1'b0;
      send(2'd1, 32'h1111_2222, 5'd1, 4'd9);
      send(2'd1, 32'h3333_4444, 5'd1, 4'd10);
      idle();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("arst_out_result", ifc.out_result, 32'd0);
      chk("arst_occupancy", 32'(occupancy), 32'd0);
      q.delete();
      #1;
      rst_n = 1'b1;
      ifc.out_ready = 1'b1;
      tick();
      send(2'd1, 32'hFFFF_FFFF, 5'd16, 4'd11);
      idle();
      tick();
      chk("post_rst_valid", 32'(ifc.out_valid), 32'd1);
      chk("post_rst_result", ifc.out_result, 32'h0000_FFFF);
      drain();

      // randomized traffic with random backpressure and occasional flush
      for (int i = 0; i < 600; i++) begin
         ifc.in_valid  = ($urandom_range(0, 3) != 0);
         ifc.in_op     = 2'($urandom_range(0, 3));
         ifc.in_a      = $urandom;
         ifc.in_shamt  = 5'($urandom_range(0, 31));
         ifc.in_tag    = TAG_W'($urandom_range(0, 15));
         ifc.out_ready = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 40) == 0);
         tick();
      end
      flush = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/shift_issue_pipe.md
Name: shift_issue_pipe

Overview:
- Two-stage, valid/ready pipelined shift unit wrapped around the team's 32-bit logical-right barrel shifter core (Barrel_Shifter_32bit or a functionally identical datapath).
- Stage 1 registers operands and does operand conditioning: bit-reversal for left shifts, fill mask for arithmetic shifts, wrap term for rotates.
- Stage 2 runs the right-shift core, post-processes, and registers the result.
- Sits between the ALU issue logic and the writeback mux, replacing the bare combinational shifter path.

Parameters:
- TAG_W, 4: width of the opaque tag carried alongside each operation, returned unchanged with its result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request this cycle
- in_a  input  32  data to shift
- in_shamt  input  5  shift amount, 0..31
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  input  TAG_W  request tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  32  shifted data
- out_tag  output  TAG_W  tag of the result
- occupancy  output  2  number of valid stages (0..2)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
  - On reset assertion: s1_valid=0, s2_valid=0, all data/tag registers=0.
  - Outputs under reset: out_valid=0, out_result=0, out_tag=0, occupancy=0, in_ready=1 (in_ready=0 only when flush=1).
- Handshake:
  - Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !flush && (!s1_valid || s2_adv), a combinational function of registered state, out_ready and flush.
- Latency and throughput:
  - Accept in cycle N -> out_valid in cycle N+2 when unstalled.
  - Throughput is 1 op/cycle while out_ready=1.
  - Results leave strictly in acceptance order.
- Stage 1 register holds: a, shamt, op, tag.
  - Conditioned operand x = bitreverse(a) for SLL, else a.
- Stage 2 computation (combinational from S1, registered into S2 on s1_adv):
  - r = x >> shamt, logical, via the core.
  - SLL: result = bitreverse(r).
  - SRL: result = r.
  - SRA: result = r | (a[31] ? ~(32'hFFFF_FFFF >> shamt) : 0).
  - ROR: result = r | (a << (32 - shamt)). The wrap term is forced to 0 when shamt=0, so ROR by 0 returns a.
  - shamt=0 returns a unchanged for every op.
- Stall:
  - When out_valid=1 and out_ready=0, S2 holds out_result/out_tag stable.
  - S1 holds if full. in_ready drops once both stages are full.
  - No drop and no duplication are permitted.
- Simultaneous events:
  - Deliver and accept in the same cycle with both stages full is legal: S2 takes S1, S1 takes the new input.
  - occupancy updates the cycle after = s1_valid + s2_valid.
- Flush:
  - While flush=1: in_ready=0 and out_valid is forced to 0 combinationally.
  - At the next edge both valids clear. Data registers may keep stale values.
  - Flush has priority over every handshake in that cycle.
- Reset mid-operation: all in-flight ops are discarded immediately; there is no partial delivery after rst_n rises.
- X-handling: data/tag registers load only on their stage's advance, so no X propagates out while out_valid=0.

Test Plan:
- SLL in_a=0x0000_0001, shamt=31, tag=1, out_ready=1 -> two cycles later out_valid=1, out_result=0x8000_0000, out_tag=1.
- Back-to-back in consecutive cycles, a=0x8000_0000, shamt=4:
  - SRA -> 0xF800_0000.
  - SRL -> 0x0800_0000, delivered on consecutive cycles.
- ROR in_a=0x1234_5678:
  - shamt=8 -> 0x7812_3456.
  - shamt=0 -> 0x1234_5678.
  - shamt=31 -> 0x2468_ACF0.
- Backpressure with out_ready=0, three back-to-back requests tags 1,2,3:
  - Tags 1 and 2 accepted; in_ready=0 on the third; occupancy=2.
  - out_result is stable while stalled.
  - Raising out_ready -> tags 1,2,3 delivered in order, each exactly once.
- Flush with occupancy=2 and in_valid=1 in the same cycle:
  - That cycle: out_valid=0, in_ready=0.
  - Next cycle: occupancy=0, no result ever appears for the flushed or offered ops.
- Assert rst_n=0 asynchronously between clock edges with occupancy=2:
  - Immediately out_valid=0, out_result=0, occupancy=0.
  - After release, a new SRL 0xFFFF_FFFF by 16 -> 0x0000_FFFF with latency 2.
